// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_pkg
//  Description : Shared types and encodings for the ALU context arbiter:
//                arbiter state enum, flag layout {Z,S,C,V}, ALU function
//                codes and condition codes ([3:1] select, [0] negate).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    localparam int FLAG_BITS = 4;
    localparam int FUNC_BITS = 4;
    localparam int COND_BITS = 4;

    // Flag bit positions inside a context word
    localparam int FLAG_Z = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ALU function codes
    localparam logic [FUNC_BITS-1:0] OP_ALU_NOP = 4'h0;
    localparam logic [FUNC_BITS-1:0] OP_ALU_ADD = 4'h1;
    localparam logic [FUNC_BITS-1:0] OP_ALU_SUB = 4'h2;
    localparam logic [FUNC_BITS-1:0] OP_ALU_AND = 4'h3;
    localparam logic [FUNC_BITS-1:0] OP_ALU_OR  = 4'h4;
    localparam logic [FUNC_BITS-1:0] OP_ALU_XOR = 4'h5;

    // Condition codes: [3:1] selects the flag, [0] inverts the test.
    // C is a borrow after SUB, so "unsigned >=" is C clear.
    localparam logic [COND_BITS-1:0] COND_ALWAYS = 4'b0000;
    localparam logic [COND_BITS-1:0] COND_EQ     = 4'b0010;
    localparam logic [COND_BITS-1:0] COND_NE     = 4'b0011;
    localparam logic [COND_BITS-1:0] COND_ULT    = 4'b0100;
    localparam logic [COND_BITS-1:0] COND_UGE    = 4'b0101;
    localparam logic [COND_BITS-1:0] COND_NEG    = 4'b0110;
    localparam logic [COND_BITS-1:0] COND_POS    = 4'b0111;
    localparam logic [COND_BITS-1:0] COND_OVF    = 4'b1000;
    localparam logic [COND_BITS-1:0] COND_NOVF   = 4'b1001;

    // Operation sequencing: restore flags, execute, write flags back
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } arb_state_e;

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches the request
//                vector starting one above last_grant, wrapping around, and
//                returns a one-hot grant plus the winning index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [SEL_BITS-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic [SEL_BITS-1:0] grant_idx_o,
    output logic                valid_o
);

    int                  cand;
    logic [SEL_BITS-1:0] cidx;

    // First requester after last_grant wins; last_grant itself is tried last
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        cand        = 0;
        cidx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cidx = cand[SEL_BITS-1:0];
            if (!valid_o && req_i[cidx]) begin
                valid_o     = 1'b1;
                grant_idx_o = cidx;
            end
        end
        grant_o[grant_idx_o] = valid_o;
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_context_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_context_arbiter
//  Description : Shares one flag-holding ALU between NUM_REQ contexts. Each
//                context owns a private {Z,S,C,V} word; every granted op is
//                sequenced restore (LOAD) -> execute (EXEC) -> writeback (WB).
//                Optional macro ALU_ARB_SAME_CTX_BYPASS_EN skips LOAD when the
//                same context issues again and the ALU still holds its flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_context_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int NUM_REQ   = 4,
    parameter int SEL_BITS  = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    // requester side
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_BITS-1:0]  req_a_i,
    input  logic [NUM_REQ*DATA_BITS-1:0]  req_b_i,
    input  logic [NUM_REQ*FUNC_BITS-1:0]  req_func_i,
    input  logic [NUM_REQ*COND_BITS-1:0]  req_cond_i,
    input  logic [NUM_REQ-1:0]            req_upd_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    output logic [DATA_BITS-1:0]          resp_data_o,
    output logic                          resp_cond_o,
    output logic [FLAG_BITS-1:0]          resp_flags_o,
    // scheduler context port
    input  logic                          ctx_wr_en_i,
    input  logic [SEL_BITS-1:0]           ctx_sel_i,
    input  logic [FLAG_BITS-1:0]          ctx_wr_flags_i,
    output logic [FLAG_BITS-1:0]          ctx_rd_flags_o,
    // ALU side
    output logic [DATA_BITS-1:0]          alu_a_o,
    output logic [DATA_BITS-1:0]          alu_b_o,
    output logic [FUNC_BITS-1:0]          alu_func_o,
    output logic [COND_BITS-1:0]          alu_cond_o,
    output logic                          alu_upd_flags_o,
    output logic                          alu_load_flags_o,
    output logic [FLAG_BITS-1:0]          alu_saved_flags_o,
    input  logic [DATA_BITS-1:0]          alu_out_i,
    input  logic                          alu_cond_holds_i,
    input  logic [FLAG_BITS-1:0]          alu_flags_i
);

    arb_state_e           state_q, state_d;
    logic [SEL_BITS-1:0]  last_grant_q;
    logic [SEL_BITS-1:0]  owner_q;
    logic [DATA_BITS-1:0] a_q, b_q;
    logic [FUNC_BITS-1:0] func_q;
    logic [COND_BITS-1:0] cond_q;
    logic                 upd_q;
    logic [FLAG_BITS-1:0] ctx_q [NUM_REQ];
    logic [DATA_BITS-1:0] resp_data_q;
    logic                 resp_cond_q;
    logic [FLAG_BITS-1:0] resp_flags_q;

    logic [NUM_REQ-1:0]   grant_oh;
    logic [SEL_BITS-1:0]  grant_idx;
    logic                 grant_vld;
    logic                 accept;
    logic                 bypass_hit;

    logic [DATA_BITS-1:0] req_a_arr    [NUM_REQ];
    logic [DATA_BITS-1:0] req_b_arr    [NUM_REQ];
    logic [FUNC_BITS-1:0] req_func_arr [NUM_REQ];
    logic [COND_BITS-1:0] req_cond_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_a_arr[gi]    = req_a_i[gi*DATA_BITS +: DATA_BITS];
        assign req_b_arr[gi]    = req_b_i[gi*DATA_BITS +: DATA_BITS];
        assign req_func_arr[gi] = req_func_i[gi*FUNC_BITS +: FUNC_BITS];
        assign req_cond_arr[gi] = req_cond_i[gi*COND_BITS +: COND_BITS];
    end

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .SEL_BITS (SEL_BITS)
    ) u_rr (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_oh),
        .grant_idx_o  (grant_idx),
        .valid_o      (grant_vld)
    );

`ifdef ALU_ARB_SAME_CTX_BYPASS_EN
    logic bypass_ok_q;

    // Bypass is safe only while the ALU flags still equal last owner's context
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bypass_ok_q <= 1'b0;
        end else if (state_q == WB) begin
            bypass_ok_q <= 1'b1;
        end else if (ctx_wr_en_i && (ctx_sel_i == owner_q)) begin
            bypass_ok_q <= 1'b0;
        end
    end

    assign bypass_hit = bypass_ok_q && (grant_idx == owner_q);
`else
    assign bypass_hit = 1'b0;
`endif

    // State sequencing and combinational grant while idle
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready_o = grant_oh;
                    accept      = 1'b1;
                    state_d     = bypass_hit ? EXEC : LOAD;
                end
            end
            LOAD:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU-side drive: each signal is live only in the state that uses it
    always_comb begin
        alu_a_o           = '0;
        alu_b_o           = '0;
        alu_func_o        = '0;
        alu_cond_o        = '0;
        alu_upd_flags_o   = 1'b0;
        alu_load_flags_o  = 1'b0;
        alu_saved_flags_o = '0;
        resp_valid_o      = '0;
        if (state_q == LOAD) begin
            alu_load_flags_o  = 1'b1;
            alu_saved_flags_o = ctx_q[owner_q];
        end
        if (state_q == EXEC) begin
            alu_a_o         = a_q;
            alu_b_o         = b_q;
            alu_func_o      = func_q;
            alu_cond_o      = cond_q;
            alu_upd_flags_o = upd_q;
        end
        resp_valid_o[owner_q] = (state_q == WB);
    end

    // Post-op flags are only live on the ALU during WB, so pass them through then
    assign resp_flags_o   = (state_q == WB) ? alu_flags_i : resp_flags_q;
    assign resp_data_o    = resp_data_q;
    assign resp_cond_o    = resp_cond_q;
    assign ctx_rd_flags_o = ctx_q[ctx_sel_i];

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winner's request at the accept edge and advance round-robin
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= SEL_BITS'(NUM_REQ - 1);
            owner_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            func_q       <= '0;
            cond_q       <= '0;
            upd_q        <= 1'b0;
        end else if (accept) begin
            last_grant_q <= grant_idx;
            owner_q      <= grant_idx;
            a_q          <= req_a_arr[grant_idx];
            b_q          <= req_b_arr[grant_idx];
            func_q       <= req_func_arr[grant_idx];
            cond_q       <= req_cond_arr[grant_idx];
            upd_q        <= req_upd_i[grant_idx];
        end
    end

    // Capture result and pre-op condition at the end of EXEC, flags at WB
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_data_q  <= '0;
            resp_cond_q  <= 1'b0;
            resp_flags_q <= '0;
        end else begin
            if (state_q == EXEC) begin
                resp_data_q <= alu_out_i;
                resp_cond_q <= alu_cond_holds_i;
            end
            if (state_q == WB) begin
                resp_flags_q <= alu_flags_i;
            end
        end
    end

    // Context file: scheduler writes, but the owner's writeback wins a collision
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                ctx_q[i] <= '0;
            end
        end else begin
            if (ctx_wr_en_i) begin
                ctx_q[ctx_sel_i] <= ctx_wr_flags_i;
            end
            if (state_q == WB) begin
                ctx_q[owner_q] <= alu_flags_i;
            end
        end
    end

endmodule : alu_context_arbiter
`default_nettype wire

// File: tb/tb_alu_context_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_context_arbiter
//  Description : Self-checking bench for alu_context_arbiter (8-bit, 4 req).
//                Contains a small flag-holding ALU model; table of directed
//                ops plus hand sequences for round-robin, reset, and the
//                same-context path (ALU_ARB_SAME_CTX_BYPASS_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_context_arbiter;
    import alu_arb_pkg::*;

    localparam int DB = 8;
    localparam int NR = 4;
`ifdef ALU_ARB_SAME_CTX_BYPASS_EN
    localparam int SAME_LAT   = 2;
    localparam int SAME_LOADS = 0;
`else
    localparam int SAME_LAT   = 3;
    localparam int SAME_LOADS = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    logic [NR*DB-1:0] req_a = '0, req_b = '0;
    logic [NR*4-1:0]  req_func = '0, req_cond = '0;
    logic [NR-1:0] req_upd = '0;
    logic [NR-1:0] resp_valid;
    logic [DB-1:0] resp_data;
    logic          resp_cond;
    logic [3:0]    resp_flags;
    logic          ctx_wr_en = 1'b0;
    logic [1:0]    ctx_sel = '0;
    logic [3:0]    ctx_wr_flags = '0;
    logic [3:0]    ctx_rd_flags;
    logic [DB-1:0] alu_a, alu_b, alu_out;
    logic [3:0]    alu_func, alu_cond, alu_saved_flags, alu_flags;
    logic          alu_upd_flags, alu_load_flags, alu_cond_holds;
    logic [11:0]   alu_next;

    int n_total = 0;
    int n_pass  = 0;
    int load_cnt = 0;

    always #5 clk = ~clk;

    alu_context_arbiter #(.DATA_BITS(DB), .NUM_REQ(NR)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_func_i(req_func),
        .req_cond_i(req_cond), .req_upd_i(req_upd),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .resp_cond_o(resp_cond), .resp_flags_o(resp_flags),
        .ctx_wr_en_i(ctx_wr_en), .ctx_sel_i(ctx_sel),
        .ctx_wr_flags_i(ctx_wr_flags), .ctx_rd_flags_o(ctx_rd_flags),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_func_o(alu_func),
        .alu_cond_o(alu_cond), .alu_upd_flags_o(alu_upd_flags),
        .alu_load_flags_o(alu_load_flags), .alu_saved_flags_o(alu_saved_flags),
        .alu_out_i(alu_out), .alu_cond_holds_i(alu_cond_holds),
        .alu_flags_i(alu_flags)
    );

    // ALU model: returns {Z,S,C,V,result}. C is carry (ADD) or borrow (SUB);
    // this ALU's S flag is N^V^C. NOP passes a and leaves flags unchanged.
    function automatic logic [11:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] f, input logic [3:0] fl);
        logic [8:0] s;
        logic [7:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0; r = a; s = '0;
        case (f)
            OP_ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_ALU_SUB: begin
                s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_ALU_AND: r = a & b;
            OP_ALU_OR:  r = a | b;
            OP_ALU_XOR: r = a ^ b;
            default:    return {fl, a};
        endcase
        return {(r == 8'h00), r[7] ^ v ^ c, c, v, r};
    endfunction

    function automatic logic cond_eval(input logic [3:0] fl, input logic [3:0] cc);
        logic t;
        case (cc[3:1])
            3'd0:    t = 1'b1;
            3'd1:    t = fl[3];
            3'd2:    t = fl[1];
            3'd3:    t = fl[2];
            3'd4:    t = fl[0];
            default: t = 1'b0;
        endcase
        return t ^ cc[0];
    endfunction

    always_comb begin
        alu_next       = alu_eval(alu_a, alu_b, alu_func, alu_flags);
        alu_out        = alu_next[7:0];
        alu_cond_holds = cond_eval(alu_flags, alu_cond);
    end

    always_ff @(posedge clk) begin
        if (reset)               alu_flags <= 4'b0000;
        else if (alu_load_flags) alu_flags <= alu_saved_flags;
        else if (alu_upd_flags)  alu_flags <= alu_next[11:8];
    end

    always @(negedge clk) begin
        if (alu_load_flags) load_cnt = load_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] a, b;
        logic [3:0] func, cond;
        logic       upd;
        logic [7:0] exp_data;
        logic       exp_cond;
        logic [3:0] exp_flags;
    } vec_t;

    task automatic drive_req(input vec_t v);
        req_a[v.idx*DB +: DB]  = v.a;
        req_b[v.idx*DB +: DB]  = v.b;
        req_func[v.idx*4 +: 4] = v.func;
        req_cond[v.idx*4 +: 4] = v.cond;
        req_upd[v.idx]         = v.upd;
    endtask

    // Issue one op alone, check grant, latency, response and resulting context
    task automatic run_op(input string nm, input vec_t v, input int exp_lat);
        int wc, lat;
        logic [3:0] oh;
        oh = 4'b0001 << v.idx;
        @(negedge clk);
        drive_req(v);
        req_valid = oh;
        #1;
        wc = 0;
        while (req_ready !== oh && wc < 16) begin @(negedge clk); #1; wc++; end
        check({nm, "_ready"}, 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid = '0;
        #1;
        lat = 1;
        while (resp_valid[v.idx] !== 1'b1 && lat < 8) begin @(negedge clk); #1; lat++; end
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nm, "_resp_valid"}, 32'(resp_valid), 32'(oh));
        check({nm, "_data"}, 32'(resp_data), 32'(v.exp_data));
        check({nm, "_cond"}, 32'(resp_cond), 32'(v.exp_cond));
        check({nm, "_flags"}, 32'(resp_flags), 32'(v.exp_flags));
        @(negedge clk);
        ctx_sel = 2'(v.idx);
        #1;
        check({nm, "_ctx"}, 32'(ctx_rd_flags), 32'(v.exp_flags));
    endtask

    task automatic ctx_write(input int sel, input logic [3:0] val, input logic [3:0] old);
        @(negedge clk);
        ctx_sel = 2'(sel); ctx_wr_en = 1'b1; ctx_wr_flags = val;
        #1;
        check("ctx_wr_no_writethrough", 32'(ctx_rd_flags), 32'(old));
        @(negedge clk);
        ctx_wr_en = 1'b0;
        #1;
        check("ctx_wr_readback", 32'(ctx_rd_flags), 32'(val));
    endtask

    vec_t vecs[7];
    vec_t v;

    initial begin
        int ng, cyc, last_cyc, strobes, lc0;
        logic [3:0] exp_oh;

        vecs[0] = '{0, 8'h7F, 8'h01, OP_ALU_ADD, COND_ALWAYS, 1'b1, 8'h80, 1'b1, 4'b0001};
        vecs[1] = '{1, 8'h00, 8'h01, OP_ALU_SUB, COND_ALWAYS, 1'b1, 8'hFF, 1'b1, 4'b0010};
        vecs[2] = '{2, 8'h11, 8'h00, OP_ALU_NOP, COND_UGE,    1'b0, 8'h11, 1'b1, 4'b0000};
        vecs[3] = '{1, 8'h22, 8'h00, OP_ALU_NOP, COND_UGE,    1'b0, 8'h22, 1'b0, 4'b0010};
        vecs[4] = '{0, 8'h44, 8'h00, OP_ALU_NOP, COND_OVF,    1'b0, 8'h44, 1'b1, 4'b0001};
        vecs[5] = '{2, 8'hF0, 8'h0F, OP_ALU_AND, COND_NE,     1'b1, 8'h00, 1'b1, 4'b1000};
        vecs[6] = '{3, 8'h33, 8'h00, OP_ALU_NOP, COND_EQ,     1'b0, 8'h33, 1'b1, 4'b1000};

        // reset state
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_alu_outputs", 32'({alu_a, alu_b, alu_func, alu_cond, alu_upd_flags,
                                      alu_load_flags, alu_saved_flags}), 0);
        check("rst_resp_regs", 32'({resp_data, resp_cond, resp_flags}), 0);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            ctx_sel = 2'(i); #1;
            check($sformatf("rst_ctx%0d", i), 32'(ctx_rd_flags), 0);
        end

        // directed op table
        for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), vecs[i], 3);
        ctx_write(3, 4'b1000, 4'b0000);
        run_op("vec6", vecs[6], 3);

        // round robin with all four requesting
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            v = '{i, 8'(i), 8'h00, OP_ALU_NOP, COND_ALWAYS, 1'b0, 8'h00, 1'b0, 4'b0000};
            drive_req(v);
        end
        req_valid = 4'hF;
        #1;
        ng = 0; cyc = 0; last_cyc = 0;
        while (ng < 6 && cyc < 60) begin
            if (req_ready != '0) begin
                exp_oh = 4'b0001 << (ng % 4);
                check($sformatf("rr_grant%0d", ng), 32'(req_ready), 32'(exp_oh));
                if (ng > 0) check($sformatf("rr_interval%0d", ng), 32'(cyc - last_cyc), 4);
                last_cyc = cyc;
                ng++;
            end
            @(negedge clk); #1; cyc++;
        end
        check("rr_grant_count", 32'(ng), 6);
        req_valid = '0;
        repeat (5) @(negedge clk);

        // reset during EXEC of req2
        v = '{2, 8'h5A, 8'h01, OP_ALU_ADD, COND_ALWAYS, 1'b1, 8'h00, 1'b0, 4'b0000};
        drive_req(v);
        req_valid = 4'b0100;
        #1;
        check("rst_mid_ready", 32'(req_ready), 32'(4'b0100));
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        check("rst_mid_exec_a", 32'(alu_a), 32'h5A);
        reset = 1'b1;
        strobes = 0;
        @(negedge clk); #1;
        if (resp_valid != '0) strobes++;
        check("rst_mid_alu_zero", 32'({alu_a, alu_b, alu_func, alu_cond, alu_upd_flags,
                                       alu_load_flags, alu_saved_flags}), 0);
        check("rst_mid_resp_data", 32'(resp_data), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (resp_valid != '0) strobes++;
        end
        check("rst_mid_no_strobe", 32'(strobes), 0);
        for (int i = 0; i < NR; i++) begin
            ctx_sel = 2'(i); #1;
            check($sformatf("rst_mid_ctx%0d", i), 32'(ctx_rd_flags), 0);
        end
        @(negedge clk);
        req_func = '0; req_upd = '0;
        req_valid = 4'b0101;
        #1;
        check("rst_first_grant", 32'(req_ready), 32'(4'b0001));
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        cyc = 0;
        while (req_ready == '0 && cyc < 10) begin @(negedge clk); #1; cyc++; end
        check("rst_second_grant", 32'(req_ready), 32'(4'b0100));
        @(negedge clk); req_valid = '0;
        repeat (5) @(negedge clk);

        // same-context back-to-back, then scheduler write forces a restore
        v = '{0, 8'hFF, 8'h01, OP_ALU_ADD, COND_ALWAYS, 1'b1, 8'h00, 1'b1, 4'b1110};
        run_op("same_a", v, 3);
        lc0 = load_cnt;
        v = '{0, 8'h10, 8'h20, OP_ALU_ADD, COND_EQ, 1'b0, 8'h30, 1'b1, 4'b1110};
        run_op("same_b", v, SAME_LAT);
        check("same_b_loads", 32'(load_cnt - lc0), 32'(SAME_LOADS));
        ctx_write(0, 4'b0001, 4'b1110);
        lc0 = load_cnt;
        v = '{0, 8'h7F, 8'h01, OP_ALU_ADD, COND_OVF, 1'b0, 8'h80, 1'b1, 4'b0001};
        run_op("same_c", v, 3);
        check("same_c_loads", 32'(load_cnt - lc0), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1);
    end

endmodule : tb_alu_context_arbiter
`default_nettype wire
